// File: rtl/pcm_to_i2s_tx_pkg.sv
// rtl/pcm_to_i2s_tx_pkg.sv - shared widths and saturation limits for the I2S output stage
package pcm_to_i2s_tx_pkg;

    localparam int NUMBER_OF_BITS  = 16;
    // Eight summed channels add three bits of growth to the per-channel sample.
    localparam int CHANNEL_GROWTH  = 3;
    localparam int DEF_IN_WIDTH    = NUMBER_OF_BITS + CHANNEL_GROWTH;
    localparam int DEF_OUT_WIDTH   = NUMBER_OF_BITS;
    localparam int DEF_SLOT_WIDTH  = 32;
    localparam int DEF_HALF_PERIOD = 2;

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int MAX_OUT = sat_max(DEF_OUT_WIDTH);
    localparam int MIN_OUT = sat_min(DEF_OUT_WIDTH);

endpackage

// File: rtl/pcm_to_i2s_tx_fifo.sv
// rtl/pcm_to_i2s_tx_fifo.sv - two-entry FIFO of {left,right} sample pairs
module pcm_pair_fifo #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcm_to_i2s_tx.sv
// rtl/pcm_to_i2s_tx.sv - buffers PCM pairs, saturates them and drives an I2S master stream
module pcm_to_i2s_tx
    import pcm_to_i2s_tx_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SLOT_WIDTH  = DEF_SLOT_WIDTH,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_left,
    input  logic [IN_WIDTH-1:0] in_right,
    output logic                sck,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                clip,
    output logic [7:0]          underrun_count
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int PW         = $clog2(FRAME_BITS);
    localparam int DW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] SLOT_P   = PW'(SLOT_WIDTH);
    localparam logic [PW-1:0] WS_ON    = PW'(SLOT_WIDTH - 1);
    localparam logic [PW-1:0] WS_OFF   = PW'(FRAME_BITS - 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

    localparam logic signed [IN_WIDTH-1:0] HI_LIM = IN_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [IN_WIDTH-1:0] LO_LIM = IN_WIDTH'(sat_min(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] MAX_WORD = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_WORD = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Returns {clipped, word}.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [IN_WIDTH-1:0] x);
        if (x > HI_LIM) begin
            return {1'b1, MAX_WORD};
        end else if (x < LO_LIM) begin
            return {1'b1, MIN_WORD};
        end else begin
            return {1'b0, x[OUT_WIDTH-1:0]};
        end
    endfunction

    logic [DW-1:0]          div_cnt;
    logic                   div_wrap;
    logic                   fall_tick;
    logic [PW-1:0]          p;
    logic [PW-1:0]          p_next;
    logic [PW-1:0]          k;
    logic                   load;
    logic                   ws_next;
    logic                   sd_next;

    logic [2*IN_WIDTH-1:0]  head;
    logic [1:0]             fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    logic [OUT_WIDTH:0]     sat_l;
    logic [OUT_WIDTH:0]     sat_r;
    logic [OUT_WIDTH-1:0]   new_left;
    logic [OUT_WIDTH-1:0]   new_right;
    logic [OUT_WIDTH-1:0]   left_word;
    logic [OUT_WIDTH-1:0]   right_word;
    logic [OUT_WIDTH-1:0]   word_sel;
    logic                   clip_hit;

    assign in_ready = (fifo_count < 2'd2);
    assign push     = in_valid && !fifo_full;
    assign pop      = load && !fifo_empty;

    pcm_pair_fifo #(
        .WIDTH (2 * IN_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_left, in_right}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign fall_tick = div_wrap && sck;
    assign p_next    = (p == P_LAST) ? '0 : p + PW'(1);
    assign load      = fall_tick && (p == P_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // An empty FIFO at load time sends a silent frame.
    always_comb begin
        sat_l     = saturate($signed(head[2*IN_WIDTH-1:IN_WIDTH]));
        sat_r     = saturate($signed(head[IN_WIDTH-1:0]));
        new_left  = fifo_empty ? '0 : sat_l[OUT_WIDTH-1:0];
        new_right = fifo_empty ? '0 : sat_r[OUT_WIDTH-1:0];
        clip_hit  = !fifo_empty && (sat_l[OUT_WIDTH] || sat_r[OUT_WIDTH]);
    end

    // The bit for p=0 must come from the word being loaded on this same edge.
    always_comb begin
        if (p_next < SLOT_P) begin
            k        = p_next;
            word_sel = load ? new_left : left_word;
        end else begin
            k        = p_next - SLOT_P;
            word_sel = right_word;
        end
        sd_next = 1'b0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (k == PW'(OUT_WIDTH - 1 - i)) begin
                sd_next = word_sel[i];
            end
        end
        ws_next = (p_next >= WS_ON) && (p_next <= WS_OFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p              <= P_LAST;
            ws             <= 1'b0;
            sd             <= 1'b0;
            frame_start    <= 1'b0;
            clip           <= 1'b0;
            underrun_count <= 8'd0;
            left_word      <= '0;
            right_word     <= '0;
        end else begin
            frame_start <= load;
            if (fall_tick) begin
                p  <= p_next;
                ws <= ws_next;
                sd <= sd_next;
            end
            if (load) begin
                left_word  <= new_left;
                right_word <= new_right;
                if (clip_hit) begin
                    clip <= 1'b1;
                end
                if (fifo_empty && (underrun_count != 8'hFF)) begin
                    underrun_count <= underrun_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_to_i2s_tx.sv
// tb/tb_pcm_to_i2s_tx.sv - directed self-checking bench for pcm_to_i2s_tx
module tb_pcm_to_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] in_left = '0;
    logic [18:0] in_right = '0;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        frame_start;
    logic        clip;
    logic [7:0]  underrun_count;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_ws;

    always #5 clk = ~clk;

    pcm_to_i2s_tx #(
        .IN_WIDTH    (19),
        .OUT_WIDTH   (16),
        .SLOT_WIDTH  (32),
        .HALF_PERIOD (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .sck            (sck),
        .ws             (ws),
        .sd             (sd),
        .frame_start    (frame_start),
        .clip           (clip),
        .underrun_count (underrun_count)
    );

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_sck_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = sck;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (!prev && sck) begin
                ok = 1'b1;
                return;
            end
            prev = sck;
        end
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL frame_start_timeout: got none expected pulse within 600 clk");
    endtask

    // Samples one frame at sck rising edges and unpacks both slots.
    task automatic grab_frame(input bit wait_start, output logic [15:0] l, output logic [15:0] r,
                              output logic [15:0] pad_l, output logic [15:0] pad_r,
                              output logic [63:0] wsv);
        bit          ok;
        logic [63:0] sdv;
        sdv = '0;
        wsv = '0;
        if (wait_start) begin
            wait_frame_start(ok);
        end
        for (int p = 0; p < 64; p++) begin
            wait_sck_rise(ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL sck_timeout: got no rise expected rise at bit %0d", p);
                break;
            end
            sdv[p] = sd;
            wsv[p] = ws;
        end
        for (int i = 0; i < 16; i++) begin
            l[15-i] = sdv[i];
            r[15-i] = sdv[32+i];
        end
        pad_l = sdv[31:16];
        pad_r = sdv[63:48];
    endtask

    task automatic test_reset();
        int first_fs;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({sck, ws, sd} !== 3'b000) begin bad++; $display("FAIL reset_lines: got %b expected 000", {sck, ws, sd}); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip: got %b expected 0", clip); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL reset_underrun: got %0d expected 0", underrun_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        @(negedge clk);
        reset    = 1'b0;
        first_fs = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                first_fs = n;
                break;
            end
        end
        total++; if (first_fs != 4) begin bad++; $display("FAIL first_frame_latency: got %0d expected 4", first_fs); end
    endtask

    task automatic test_normal();
        logic [15:0] l, r, pl, pr;
        logic [63:0] wsv;
        do_reset();
        in_left  = 19'd291;
        in_right = -19'sd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        grab_frame(1'b1, l, r, pl, pr, wsv);
        total++; if (l !== 16'h0123) begin bad++; $display("FAIL normal_left: got %h expected 0123", l); end
        total++; if (pl !== 16'h0000) begin bad++; $display("FAIL normal_left_pad: got %h expected 0000", pl); end
        total++; if (r !== 16'hFFFB) begin bad++; $display("FAIL normal_right: got %h expected fffb", r); end
        total++; if (pr !== 16'h0000) begin bad++; $display("FAIL normal_right_pad: got %h expected 0000", pr); end
        total++; if (wsv !== exp_ws) begin bad++; $display("FAIL normal_ws: got %h expected %h", wsv, exp_ws); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL normal_underrun: got %0d expected 0", underrun_count); end
    endtask

    task automatic test_saturation();
        logic [15:0] l, r, pl, pr;
        logic [63:0] wsv;
        do_reset();
        in_left  = 19'sd70000;
        in_right = -19'sd70000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_left  = 19'sd100;
        in_right = -19'sd100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        grab_frame(1'b1, l, r, pl, pr, wsv);
        total++; if (l !== 16'h7FFF) begin bad++; $display("FAIL sat_left: got %h expected 7fff", l); end
        total++; if (r !== 16'h8000) begin bad++; $display("FAIL sat_right: got %h expected 8000", r); end
        total++; if (clip !== 1'b1) begin bad++; $display("FAIL sat_clip: got %b expected 1", clip); end
        grab_frame(1'b1, l, r, pl, pr, wsv);
        total++; if (l !== 16'h0064) begin bad++; $display("FAIL sat_next_left: got %h expected 0064", l); end
        total++; if (r !== 16'hFF9C) begin bad++; $display("FAIL sat_next_right: got %h expected ff9c", r); end
        total++; if (clip !== 1'b1) begin bad++; $display("FAIL sat_clip_sticky: got %b expected 1", clip); end
    endtask

    task automatic test_underrun();
        bit any_sd;
        bit seen;
        int expct;
        do_reset();
        any_sd = 1'b0;
        for (int f = 1; f <= 300; f++) begin
            seen = 1'b0;
            for (int n = 0; n < 400; n++) begin
                @(posedge clk);
                #1;
                if (sd) any_sd = 1'b1;
                if (frame_start) begin
                    seen = 1'b1;
                    break;
                end
            end
            expct = (f < 255) ? f : 255;
            total++;
            if (!seen || underrun_count !== 8'(expct)) begin
                bad++;
                $display("FAIL underrun_frame_%0d: got %0d expected %0d", f, underrun_count, expct);
            end
        end
        total++; if (any_sd !== 1'b0) begin bad++; $display("FAIL underrun_sd: got 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        logic [18:0] pl_v [3];
        logic [18:0] pr_v [3];
        logic [15:0] el [3];
        logic [15:0] er [3];
        int          acc [3];
        int          idx;
        int          fs_cyc;
        bit          rdy;
        logic [15:0] l, r, pl, pr;
        logic [63:0] wsv;
        pl_v[0] = 19'sd1000;   pr_v[0] = -19'sd1000; el[0] = 16'h03E8; er[0] = 16'hFC18;
        pl_v[1] = -19'sd32768; pr_v[1] = 19'sd32767;  el[1] = 16'h8000; er[1] = 16'h7FFF;
        pl_v[2] = 19'sd12345;  pr_v[2] = -19'sd2;     el[2] = 16'h3039; er[2] = 16'hFFFE;
        do_reset();
        idx    = 0;
        fs_cyc = 0;
        for (int i = 0; i < 3; i++) acc[i] = 0;
        for (int cyc = 1; cyc <= 12 && idx < 3; cyc++) begin
            in_left  = pl_v[idx];
            in_right = pr_v[idx];
            in_valid = 1'b1;
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (frame_start) fs_cyc = cyc;
            if (rdy) begin
                acc[idx] = cyc;
                idx++;
            end
            if (cyc == 3) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        total++; if (acc[0] != 1 || acc[1] != 2) begin bad++; $display("FAIL bp_first_two: got %0d,%0d expected 1,2", acc[0], acc[1]); end
        total++; if (fs_cyc != 4) begin bad++; $display("FAIL bp_load_cycle: got %0d expected 4", fs_cyc); end
        total++; if (acc[2] != 5) begin bad++; $display("FAIL bp_third_accept: got %0d expected 5", acc[2]); end
        for (int f = 0; f < 3; f++) begin
            grab_frame(f != 0, l, r, pl, pr, wsv);
            total++; if (l !== el[f]) begin bad++; $display("FAIL bp_left_%0d: got %h expected %h", f, l, el[f]); end
            total++; if (r !== er[f]) begin bad++; $display("FAIL bp_right_%0d: got %h expected %h", f, r, er[f]); end
        end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL bp_no_clip: got %b expected 0", clip); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL bp_underrun: got %0d expected 0", underrun_count); end
    endtask

    task automatic test_async_reset();
        bit          ok;
        logic [15:0] l, r, pl, pr;
        logic [63:0] wsv;
        do_reset();
        in_left  = 19'sd70000;
        in_right = 19'sd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_left  = 19'sd7;
        in_right = 19'sd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (164) @(posedge clk);
        #3;
        total++; if (ws !== 1'b1 || sck !== 1'b1 || clip !== 1'b1) begin bad++; $display("FAIL ar_pre_state: got ws=%b sck=%b clip=%b expected 1 1 1", ws, sck, clip); end
        reset = 1'b1;
        #1;
        total++; if ({sck, ws, sd, frame_start} !== 4'b0000) begin bad++; $display("FAIL ar_lines: got %b expected 0000", {sck, ws, sd, frame_start}); end
        total++; if (clip !== 1'b0 || underrun_count !== 8'd0) begin bad++; $display("FAIL ar_status: got clip=%b cnt=%0d expected 0 0", clip, underrun_count); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_frame_start(ok);
        total++; if (underrun_count !== 8'd1) begin bad++; $display("FAIL ar_underrun: got %0d expected 1", underrun_count); end
        grab_frame(1'b0, l, r, pl, pr, wsv);
        total++; if (l !== 16'h0000 || r !== 16'h0000) begin bad++; $display("FAIL ar_flushed: got %h %h expected 0000 0000", l, r); end
    endtask

    initial begin
        for (int p = 0; p < 64; p++) exp_ws[p] = (p >= 31 && p <= 62);
        test_reset();
        test_normal();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
